// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: FSM states, frame constants and
// CPU instruction encodings that benches may reuse when building images.
package program_loader_pkg;

  typedef enum logic [3:0] {
    IDLE,
    HDR_AH,
    HDR_AL,
    HDR_CH,
    HDR_CL,
    DATA,
    WRITE,
    CHECK,
    RUN,
    ERROR
  } loader_state_e;

  localparam logic [7:0] LOADER_SYNC_BYTE = 8'hA5;
  localparam int HDR_ADRS_BYTES = 2;
  localparam int HDR_CNT_BYTES  = 2;
  localparam int CHK_BYTES      = 1;

  localparam int OPCODE_W   = 6;
  localparam int OPCODE_LSB = 26;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

  // Only the low adrs_size bits of the start address are meaningful, so the
  // frame overflows when the masked start plus the word count passes the top.
  function automatic logic frame_overflows(input logic [15:0] start,
                                           input logic [15:0] count,
                                           input int adrs_size);
    logic [31:0] base;
    logic [31:0] span;
    base = {16'h0000, start} & ((32'd1 << adrs_size) - 32'd1);
    span = base + {16'h0000, count};
    return span > (32'd1 << adrs_size);
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and CPU memory write bus of the program loader.
interface program_loader_if #(
  parameter int DATA_SIZE = 32,
  parameter int ADRS_SIZE = 11
) ();
  logic [7:0]           rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic [DATA_SIZE-1:0] w_instruction;
  logic [ADRS_SIZE-1:0] w_adrs;
  logic                 w_enable;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, w_instruction, w_adrs, w_enable
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, w_instruction, w_adrs, w_enable
  );
endinterface

// File: rtl/program_loader_word_assembler.sv
// Shifts payload bytes MSB-first into a word and keeps the running XOR of
// every payload byte; word_done flags the byte that completes a word.
module program_loader_word_assembler #(
  parameter int DATA_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 shift_en,
  input  logic [7:0]           byte_in,
  output logic [DATA_SIZE-1:0] next_word,
  output logic                 word_done,
  output logic [7:0]           checksum
);
  localparam int BYTES = DATA_SIZE / 8;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [DATA_SIZE-1:0] shift_reg;
  logic [CNT_W-1:0]     byte_cnt;

  // next_word is exposed combinationally so the top can latch the finished
  // word on the same edge that accepts its last byte.
  assign next_word = (shift_reg << 8) | DATA_SIZE'(byte_in);
  assign word_done = shift_en && (byte_cnt == CNT_W'(BYTES - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      shift_reg <= '0;
      byte_cnt  <= '0;
      checksum  <= '0;
    end else if (shift_en) begin
      shift_reg <= next_word;
      checksum  <= checksum ^ byte_in;
      byte_cnt  <= word_done ? '0 : byte_cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/program_loader.sv
// Frame-driven loader: parses SYNC/address/count header, writes payload words
// into CPU memory and releases cpu_en once the payload XOR checksum matches.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int         DATA_SIZE = 32,
  parameter int         ADRS_SIZE = 11,
  parameter logic [7:0] SYNC_BYTE = LOADER_SYNC_BYTE
) (
  input  logic              sys_clk,
  input  logic              reset,
  program_loader_if.slave   bus,
  output logic              cpu_en,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_error
);
  loader_state_e        state;
  logic [7:0]           adrs_hi;
  logic [7:0]           adrs_lo;
  logic [7:0]           cnt_hi;
  logic [ADRS_SIZE-1:0] addr;
  logic [15:0]          words_left;
  logic [15:0]          start_field;
  logic [15:0]          count_field;
  logic                 xfer;
  logic                 at_rest;
  logic                 sync_seen;
  logic                 shift_en;
  logic                 word_done;
  logic [DATA_SIZE-1:0] next_word;
  logic [7:0]           checksum;

  assign xfer        = bus.rx_valid && bus.rx_ready;
  assign at_rest     = (state == IDLE) || (state == RUN) || (state == ERROR);
  assign sync_seen   = xfer && at_rest && (bus.rx_data == SYNC_BYTE);
  assign shift_en    = xfer && (state == DATA);
  assign start_field = {adrs_hi, adrs_lo};
  assign count_field = {cnt_hi, bus.rx_data};

  program_loader_word_assembler #(.DATA_SIZE(DATA_SIZE)) u_word_assembler (
    .clk      (sys_clk),
    .reset    (reset),
    .clear    (sync_seen),
    .shift_en (shift_en),
    .byte_in  (bus.rx_data),
    .next_word(next_word),
    .word_done(word_done),
    .checksum (checksum)
  );

  // rx_ready is only withheld during the single WRITE cycle.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state             <= IDLE;
      bus.rx_ready      <= 1'b0;
      bus.w_instruction <= '0;
      bus.w_adrs        <= '0;
      bus.w_enable      <= 1'b0;
      cpu_en            <= 1'b0;
      load_busy         <= 1'b0;
      load_done         <= 1'b0;
      load_error        <= 1'b0;
      adrs_hi           <= '0;
      adrs_lo           <= '0;
      cnt_hi            <= '0;
      addr              <= '0;
      words_left        <= '0;
    end else begin
      bus.rx_ready <= 1'b1;
      bus.w_enable <= 1'b0;
      load_done    <= 1'b0;
      case (state)
        IDLE, RUN, ERROR: begin
          if (sync_seen) begin
            state      <= HDR_AH;
            cpu_en     <= 1'b0;
            load_error <= 1'b0;
            load_busy  <= 1'b1;
          end
        end
        HDR_AH: if (xfer) begin adrs_hi <= bus.rx_data; state <= HDR_AL; end
        HDR_AL: if (xfer) begin adrs_lo <= bus.rx_data; state <= HDR_CH; end
        HDR_CH: if (xfer) begin cnt_hi  <= bus.rx_data; state <= HDR_CL; end
        HDR_CL: begin
          if (xfer) begin
            addr       <= ADRS_SIZE'(start_field);
            words_left <= count_field;
            if (frame_overflows(start_field, count_field, ADRS_SIZE)) begin
              state      <= ERROR;
              load_error <= 1'b1;
              load_busy  <= 1'b0;
            end else if (count_field == 16'd0) begin
              state <= CHECK;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (word_done) begin
            state             <= WRITE;
            bus.rx_ready      <= 1'b0;
            bus.w_enable      <= 1'b1;
            bus.w_instruction <= next_word;
            bus.w_adrs        <= addr;
          end
        end
        WRITE: begin
          addr       <= addr + ADRS_SIZE'(1);
          words_left <= words_left - 16'd1;
          state      <= (words_left == 16'd1) ? CHECK : DATA;
        end
        CHECK: begin
          if (xfer) begin
            load_busy <= 1'b0;
            if (bus.rx_data == checksum) begin
              state     <= RUN;
              cpu_en    <= 1'b1;
              load_done <= 1'b1;
            end else begin
              state      <= ERROR;
              load_error <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed and randomized frames are
// compared against a frame-level model of the loader's expected writes.
module tb_program_loader;
  import program_loader_pkg::*;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    int unsigned at;
    logic [31:0] adrs;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  logic cpu_en, load_busy, load_done, load_error;

  program_loader_if bus ();

  program_loader dut (
    .sys_clk   (clk),
    .reset     (reset),
    .bus       (bus),
    .cpu_en    (cpu_en),
    .load_busy (load_busy),
    .load_done (load_done),
    .load_error(load_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int unsigned acc_bytes = 0;
  logic xfer_prev = 1'b0;
  logic mon_en = 1'b0;
  wr_t obs_w[$];
  wr_t exp_w[$];
  bit hdr_err;
  bit exp_ok;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Count accepted bytes and remember whether the last edge carried a transfer.
  always @(posedge clk) begin
    xfer_prev = bus.rx_valid && bus.rx_ready && !reset;
    if (xfer_prev) acc_bytes++;
  end

  // Continuous invariants: ready only drops for the write strobe, and every
  // strobe follows an accepted byte directly.
  always @(negedge clk) begin
    if (mon_en) begin
      checkOutput("ready_vs_write", 32'(bus.rx_ready), 32'(!bus.w_enable));
      if (bus.w_enable) begin
        checkOutput("strobe_after_byte", 32'(xfer_prev), 32'd1);
        obs_w.push_back('{acc_bytes, 32'(bus.w_adrs), bus.w_instruction});
      end
    end
  end

  // Frame-level model: which writes a frame should cause and how it ends.
  task automatic buildModel(input byte_q_t f);
    int unsigned start, n;
    logic [7:0] chk;
    logic [31:0] word;
    exp_w.delete();
    hdr_err = 0;
    exp_ok = 0;
    start = ((int'(f[1]) << 8) | int'(f[2])) % 2048;
    n = (int'(f[3]) << 8) | int'(f[4]);
    if (start + n > 2048) begin
      hdr_err = 1;
      return;
    end
    chk = 8'h00;
    for (int j = 0; j < int'(n); j++) begin
      word = 32'h0;
      for (int b = 0; b < 4; b++) begin
        word = (word << 8) | 32'(f[5 + 4*j + b]);
        chk = chk ^ f[5 + 4*j + b];
      end
      exp_w.push_back('{5 + 4*(j+1), 32'(start + j), word});
    end
    exp_ok = (f[5 + 4*n] == chk);
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit gaps);
    int waited;
    if (gaps) begin
      int gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_data = 8'($urandom);
      end
    end
    @(negedge clk);
    bus.rx_data = b;
    bus.rx_valid = 1'b1;
    waited = 0;
    while (bus.rx_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 20) checkOutput("handshake_timeout", 32'(bus.rx_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic sendFrame(input byte_q_t f, input byte_q_t garbage, input bit gaps);
    int unsigned base;
    int wi;
    foreach (garbage[g]) applyStimulus(garbage[g], gaps);
    buildModel(f);
    obs_w.delete();
    base = acc_bytes;
    wi = 0;
    for (int i = 0; i < f.size(); i++) begin
      applyStimulus(f[i], gaps);
      if (i == 0) begin
        @(negedge clk);
        checkOutput("sync_cpu_en", 32'(cpu_en), 32'd0);
        checkOutput("sync_error_clear", 32'(load_error), 32'd0);
        checkOutput("sync_busy", 32'(load_busy), 32'd1);
      end else if (hdr_err && i == 4) begin
        @(negedge clk);
        checkOutput("hdr_wrap_error", 32'(load_error), 32'd1);
        checkOutput("hdr_wrap_busy", 32'(load_busy), 32'd0);
        checkOutput("hdr_wrap_cpu_en", 32'(cpu_en), 32'd0);
      end else if (!hdr_err && wi < exp_w.size() && exp_w[wi].at == 32'(i + 1)) begin
        @(negedge clk);
        checkOutput("write_strobe", 32'(bus.w_enable), 32'd1);
        checkOutput("write_adrs", 32'(bus.w_adrs), exp_w[wi].adrs);
        checkOutput("write_data", bus.w_instruction, exp_w[wi].data);
        wi++;
      end else if (!hdr_err && i == f.size() - 1) begin
        @(negedge clk);
        checkOutput("end_cpu_en", 32'(cpu_en), 32'(exp_ok));
        checkOutput("end_load_done", 32'(load_done), 32'(exp_ok));
        checkOutput("end_load_error", 32'(load_error), 32'(!exp_ok));
        checkOutput("end_busy", 32'(load_busy), 32'd0);
        @(negedge clk);
        checkOutput("done_one_cycle", 32'(load_done), 32'd0);
      end
    end
    @(negedge clk);
    checkOutput("write_count", 32'(obs_w.size()), 32'(exp_w.size()));
    for (int j = 0; j < obs_w.size() && j < exp_w.size(); j++) begin
      checkOutput("write_offset", obs_w[j].at - base, exp_w[j].at);
      checkOutput("logged_adrs", obs_w[j].adrs, exp_w[j].adrs);
      checkOutput("logged_data", obs_w[j].data, exp_w[j].data);
    end
  endtask

  task automatic checkResetValues(input string phase);
    checkOutput({phase, "_rx_ready"}, 32'(bus.rx_ready), 32'd0);
    checkOutput({phase, "_w_instruction"}, bus.w_instruction, 32'd0);
    checkOutput({phase, "_w_adrs"}, 32'(bus.w_adrs), 32'd0);
    checkOutput({phase, "_w_enable"}, 32'(bus.w_enable), 32'd0);
    checkOutput({phase, "_cpu_en"}, 32'(cpu_en), 32'd0);
    checkOutput({phase, "_busy"}, 32'(load_busy), 32'd0);
    checkOutput({phase, "_done"}, 32'(load_done), 32'd0);
    checkOutput({phase, "_error"}, 32'(load_error), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    byte_q_t fr, none, gb;
    int unsigned n, start;
    logic [7:0] chk, pb;

    none = {};
    gb = '{8'h3C, 8'h00};
    reset = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetValues("reset");
    reset = 1'b0;
    @(negedge clk);
    checkOutput("idle_rx_ready", 32'(bus.rx_ready), 32'd1);
    mon_en = 1'b1;

    fr = '{LOADER_SYNC_BYTE, 8'h00, 8'h00, 8'h00, 8'h02,
           8'h00, 8'h00, 8'h00, 8'h0D, 8'h00, 8'h00, 8'h00, 8'h0B, 8'h06};
    sendFrame(fr, none, 0);

    fr[13] = 8'h07;
    sendFrame(fr, none, 0);

    fr = '{LOADER_SYNC_BYTE, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00};
    sendFrame(fr, none, 0);

    fr = '{LOADER_SYNC_BYTE, 8'h07, 8'hFF, 8'h00, 8'h02};
    sendFrame(fr, none, 0);

    fr = '{LOADER_SYNC_BYTE, 8'h00, 8'h00, 8'h00, 8'h02,
           8'h00, 8'h00, 8'h00, 8'h0D, 8'h00, 8'h00, 8'h00, 8'h0B, 8'h06};
    sendFrame(fr, gb, 1);

    for (int k = 0; k < 3; k++) begin
      n = $urandom_range(1, 3);
      start = $urandom_range(0, 2048 - n);
      fr = '{LOADER_SYNC_BYTE, 8'(start >> 8) | ((k == 0) ? 8'hF8 : 8'h00),
             8'(start), 8'h00, 8'(n)};
      chk = 8'h00;
      for (int b = 0; b < 4 * int'(n); b++) begin
        pb = 8'($urandom);
        if (k == 1 && b == 2) pb = LOADER_SYNC_BYTE;
        fr.push_back(pb);
        chk = chk ^ pb;
      end
      fr.push_back((k == 2) ? (chk ^ 8'h81) : chk);
      gb = '{8'h3C, 8'h00, 8'($urandom_range(0, 8'hA4))};
      sendFrame(fr, gb, 1);
    end

    fr = '{LOADER_SYNC_BYTE, 8'h00, 8'h00, 8'h00, 8'h02, 8'h12, 8'h34};
    foreach (fr[i]) applyStimulus(fr[i], 0);
    @(negedge clk);
    mon_en = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkResetValues("midreset");
    @(negedge clk);
    mon_en = 1'b1;

    fr = '{LOADER_SYNC_BYTE, 8'h00, 8'h00, 8'h00, 8'h02,
           8'h00, 8'h00, 8'h00, 8'h0D, 8'h00, 8'h00, 8'h00, 8'h0B, 8'h06};
    sendFrame(fr, none, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
